// File: rtl/orion_video_scan.sv
// Orion-Pro raster timing generator, video-RAM fetch engine and RGBI pixel path.
// Optional border colour outside the active area: define VIDEO_BORDER_EN.
module orion_video_scan #(
   parameter int H_ACTIVE = 384,
   parameter int H_TOTAL  = 512,
   parameter int HS_START = 416,
   parameter int HS_LEN   = 32,
   parameter int V_ACTIVE = 256,
   parameter int V_TOTAL  = 312,
   parameter int VS_START = 272,
   parameter int VS_LEN   = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [4:0]  i_video_mode,
   input  logic [7:0]  i_screen_mode,
   input  logic [7:0]  i_colors,
   input  logic [3:0]  i_border,
   input  logic        i_int_en,
   input  logic        i_int_ack,
   output logic        o_rd_req,
   output logic [15:0] o_rd_addr,
   output logic        o_rd_plane,
   input  logic        i_rd_ack,
   input  logic [7:0]  i_rd_data,
   output logic [3:0]  o_rgbi,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic        o_frame_end,
   output logic        o_int_n,
   output logic        o_underrun
);

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
   localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
   localparam logic [15:0] H_ACT   = 16'(H_ACTIVE);
   localparam logic [15:0] V_ACT   = 16'(V_ACTIVE);
   localparam logic [15:0] H_COL0  = 16'(H_TOTAL - 8);
   localparam logic [15:0] H_FLAST = 16'(H_ACTIVE - 8);
   localparam logic [15:0] HS_S    = 16'(HS_START);
   localparam logic [15:0] HS_E    = 16'(HS_START + HS_LEN);
   localparam logic [15:0] VS_S    = 16'(VS_START);
   localparam logic [15:0] VS_E    = 16'(VS_START + VS_LEN);

   typedef enum logic [1:0] {
      IDLE,
      RD0,
      RD1,
      DONE
   } fetch_state_t;

   logic [HW-1:0] hcnt;
   logic [HW-1:0] hcnt_nxt;
   logic [VW-1:0] vcnt;
   logic [VW-1:0] vcnt_nxt;
   logic [15:0]   h_w;
   logic [15:0]   v_w;
   logic [15:0]   hn_w;
   logic [15:0]   vn_w;

   logic          active;
   logic          hs_c;
   logic          vs_c;
   logic          frame_end_nxt;
   logic          irq_pend;

   fetch_state_t  state_q;
   fetch_state_t  state_d;
   logic          restart_q;
   logic          busy;
   logic          done;
   logic          slot_edge;
   logic          col0_slot;
   logic          fetch_go;
   logic [15:0]   row_c0_w;
   logic [5:0]    col_mid;
   logic [1:0]    scr_sel;
   logic [1:0]    scr_q;
   logic [15:0]   next_addr;
   logic [15:0]   addr_q;

   logic [7:0]    pix_buf;
   logic [7:0]    attr_buf;
   logic [7:0]    shift_q;
   logic [7:0]    attr_q;
   logic [1:0]    mode_q;
   logic [3:0]    pix_color;
   logic [3:0]    blank_color;
   logic          unused_ok;

   assign h_w  = 16'(hcnt);
   assign v_w  = 16'(vcnt);
   assign hn_w = 16'(hcnt_nxt);
   assign vn_w = 16'(vcnt_nxt);

   always_comb begin
      hcnt_nxt = hcnt + HW'(1);
      vcnt_nxt = vcnt;
      if (h_w == H_LAST) begin
         hcnt_nxt = '0;
         vcnt_nxt = (v_w == V_LAST) ? '0 : vcnt + VW'(1);
      end
   end

   assign active        = (h_w < H_ACT) && (v_w < V_ACT);
   assign hs_c          = (h_w >= HS_S) && (h_w < HS_E);
   assign vs_c          = (v_w >= VS_S) && (v_w < VS_E);
   assign frame_end_nxt = (hn_w == 16'd0) && (vn_w == V_ACT);

   // Each 8-clock slot fetches the byte shown in the following slot.
   assign slot_edge = (hcnt[2:0] == 3'd7);
   assign col0_slot = (hn_w == H_COL0);
   assign row_c0_w  = (vn_w == V_LAST) ? 16'd0 : vn_w + 16'd1;
   assign col_mid   = hn_w[8:3] + 6'd1;
   assign scr_sel   = col0_slot ? i_screen_mode[1:0] : scr_q;

   always_comb begin
      fetch_go = 1'b0;
      if (slot_edge) begin
         if (col0_slot)
            fetch_go = (row_c0_w < V_ACT);
         else
            fetch_go = (hn_w < H_FLAST) && (vn_w < V_ACT);
      end
   end

   always_comb begin
      next_addr = {~scr_sel, col_mid, vn_w[7:0]};
      if (col0_slot)
         next_addr = {~scr_sel, 6'd0, row_c0_w[7:0]};
   end

   assign busy = (state_q == RD0) || (state_q == RD1);
   assign done = (state_q == DONE);

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // A slot boundary always wins: a fetch still in flight is abandoned.
   always_comb begin
      state_d = state_q;
      if (slot_edge) begin
         state_d = (busy || !fetch_go) ? IDLE : RD0;
      end else begin
         unique case (state_q)
            IDLE: if (restart_q) state_d = RD0;
            RD0: begin
               if (i_rd_ack)
                  state_d = (i_video_mode[1:0] == 2'd2) ? RD1 : DONE;
            end
            RD1: if (i_rd_ack) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   assign o_rd_req   = busy;
   assign o_rd_plane = (state_q == RD1);
   assign o_rd_addr  = addr_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         restart_q  <= 1'b0;
         addr_q     <= '0;
         scr_q      <= '0;
         pix_buf    <= '0;
         attr_buf   <= '0;
         shift_q    <= '0;
         attr_q     <= '0;
         mode_q     <= '0;
         o_underrun <= 1'b0;
      end else begin
         restart_q <= slot_edge & busy & fetch_go;
         if (fetch_go)
            addr_q <= next_addr;
         if (slot_edge && col0_slot)
            scr_q <= i_screen_mode[1:0];
         if (!slot_edge && i_rd_ack) begin
            if (state_q == RD0) pix_buf <= i_rd_data;
            if (state_q == RD1) attr_buf <= i_rd_data;
         end
         if (slot_edge) begin
            shift_q <= done ? pix_buf : 8'h00;
            attr_q  <= done ? attr_buf : 8'h00;
            mode_q  <= i_video_mode[1:0];
            if (busy)
               o_underrun <= 1'b1;
         end else begin
            shift_q <= {shift_q[6:0], 1'b0};
         end
      end
   end

   always_comb begin
      pix_color = 4'h0;
      unique case (1'b1)
         (mode_q == 2'd1): pix_color = shift_q[7] ? i_colors[3:0] : i_colors[7:4];
         (mode_q == 2'd2): pix_color = shift_q[7] ? attr_q[3:0] : attr_q[7:4];
         default:          pix_color = shift_q[7] ? 4'hF : 4'h0;
      endcase
   end

`ifdef VIDEO_BORDER_EN
   assign blank_color = (hs_c || vs_c) ? 4'h0 : i_border;
   assign unused_ok   = ^{i_video_mode[4:2], i_screen_mode[7:2]};
`else
   assign blank_color = 4'h0;
   assign unused_ok   = ^{i_video_mode[4:2], i_screen_mode[7:2], i_border};
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         hcnt        <= '0;
         vcnt        <= '0;
         o_rgbi      <= 4'h0;
         o_hs        <= 1'b0;
         o_vs        <= 1'b0;
         o_de        <= 1'b0;
         o_frame_end <= 1'b0;
         irq_pend    <= 1'b0;
      end else begin
         hcnt        <= hcnt_nxt;
         vcnt        <= vcnt_nxt;
         o_de        <= active;
         o_hs        <= hs_c;
         o_vs        <= vs_c;
         o_rgbi      <= active ? pix_color : blank_color;
         o_frame_end <= frame_end_nxt;
         if (o_frame_end)
            irq_pend <= 1'b1;
         else if (i_int_ack || !i_int_en)
            irq_pend <= 1'b0;
      end
   end

   assign o_int_n = !(irq_pend && i_int_en);

endmodule
